// File: rtl/chunked_ripple_adder.sv
// chunked_ripple_adder
//   Multi-cycle ripple-carry adder. Computes a + b + cin (modulo 2^WIDTH),
//   CHUNK bits per clock. Each chunk is a chain of CHUNK full-adder cells,
//   and the chunk's carry-out is registered into the next chunk. The longest
//   combinational path is therefore CHUNK cells, not WIDTH cells.
//
// Parameters
//   WIDTH  operand/sum width; must be a multiple of CHUNK
//   CHUNK  bits added per cycle (1..WIDTH)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_valid   in   operands a/b/cin valid
//   in_ready   out  operands accepted (high only in IDLE, forced low in reset)
//   a, b       in   WIDTH-bit operands
//   cin        in   carry into bit 0
//   out_valid  out  sum/cout/carries (and overflow) valid (high in DONE)
//   out_ready  in   consumer accepts the result
//   sum        out  a + b + cin, modulo 2^WIDTH
//   cout       out  carry out of bit WIDTH-1
//   carries    out  carries[k] = carry out of chunk k
//   dbg_state  out  current FSM state (IDLE=0, RUN=1, DONE=2)
//   overflow   out  signed overflow; only present with RIPPLE_ADDER_OVERFLOW_EN
//
// Build option
//   RIPPLE_ADDER_OVERFLOW_EN  adds the overflow port and its register.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high (and rst is low). The producer holds its data while valid is high and
// ready is low; the consumer side sees out_valid held with stable data until
// out_ready is seen high.
module chunked_ripple_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         sum,
  output logic                     cout,
  output logic [WIDTH/CHUNK-1:0]   carries,
  output logic [1:0]               dbg_state
`ifdef RIPPLE_ADDER_OVERFLOW_EN
  ,
  output logic                     overflow
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic [NCHUNK-1:0] carries_q, carries_d;
`ifdef RIPPLE_ADDER_OVERFLOW_EN
  logic              ovf_q, ovf_d;
`endif

  // Current chunk operands and the full-adder chain over them.
  logic [CHUNK-1:0]  ch_a, ch_b, ch_s;
  logic [CHUNK:0]    ch_c;
  logic              last_chunk;

  always_comb begin
    ch_a = '0;
    ch_b = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx_q == IDXW'(k)) begin
        ch_a = a_q[k*CHUNK +: CHUNK];
        ch_b = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  always_comb begin
    ch_s    = '0;
    ch_c    = '0;
    ch_c[0] = carry_q;
    for (int i = 0; i < CHUNK; i++) begin
      ch_s[i]   = ch_a[i] ^ ch_b[i] ^ ch_c[i];
      ch_c[i+1] = (ch_a[i] & ch_b[i]) | (ch_a[i] & ch_c[i]) | (ch_b[i] & ch_c[i]);
    end
  end

  assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    carries_d = carries_q;
`ifdef RIPPLE_ADDER_OVERFLOW_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d       = a;
          b_d       = b;
          carry_d   = cin;
          idx_d     = '0;
          sum_d     = '0;
          cout_d    = 1'b0;
          carries_d = '0;
`ifdef RIPPLE_ADDER_OVERFLOW_EN
          ovf_d     = 1'b0;
`endif
          state_d   = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < NCHUNK; k++) begin
          if (idx_q == IDXW'(k)) begin
            sum_d[k*CHUNK +: CHUNK] = ch_s;
            carries_d[k]            = ch_c[CHUNK];
          end
        end
        carry_d = ch_c[CHUNK];
        idx_d   = idx_q + IDXW'(1);
        if (last_chunk) begin
          cout_d  = ch_c[CHUNK];
`ifdef RIPPLE_ADDER_OVERFLOW_EN
          // Carry into the MSB differs from carry out of it.
          ovf_d   = ch_c[CHUNK-1] ^ ch_c[CHUNK];
`endif
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      carries_q <= '0;
`ifdef RIPPLE_ADDER_OVERFLOW_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      carry_q   <= carry_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      carries_q <= carries_d;
`ifdef RIPPLE_ADDER_OVERFLOW_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  // in_ready is gated by rst directly so no accept can be advertised in reset.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign carries   = carries_q;
  assign dbg_state = state_q;
`ifdef RIPPLE_ADDER_OVERFLOW_EN
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_ripple_adder.sv
module tb_chunked_ripple_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT 16/4 ----------------
  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, sum16;
  logic        cin16, cout16;
  logic [3:0]  carries16;
  logic [1:0]  st16;
`ifdef RIPPLE_ADDER_OVERFLOW_EN
  logic        ovf16;
`endif

  chunked_ripple_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16), .carries(carries16),
    .dbg_state(st16)
`ifdef RIPPLE_ADDER_OVERFLOW_EN
    , .overflow(ovf16)
`endif
  );

  // ---------------- DUT 8/8 ----------------
  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  a8, b8, sum8;
  logic        cin8, cout8;
  logic [0:0]  carries8;
  logic [1:0]  st8;
`ifdef RIPPLE_ADDER_OVERFLOW_EN
  logic        ovf8;
`endif

  chunked_ripple_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .carries(carries8),
    .dbg_state(st8)
`ifdef RIPPLE_ADDER_OVERFLOW_EN
    , .overflow(ovf8)
`endif
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q[$];   // {ovf, cout, sum[7:0]} for the 8-bit random run

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation on the 16-bit DUT and check the result once DONE is
  // reached. The output handshake is left to the caller.
  task automatic op16(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                      input logic tc, input logic [15:0] es, input logic ec,
                      input logic [3:0] ecar, input logic eo);
    int n;
    a16 = ta; b16 = tb_; cin16 = tc; in_valid16 = 1'b1;
    n = 0;
    while (!in_ready16 && n < 20) begin step(); n++; end
    chk({tag, "_in_ready_before"}, 32'(in_ready16), 32'd1);
    step();
    in_valid16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    n = 0;
    while (!out_valid16 && n < 20) begin
      chk({tag, "_in_ready_busy"}, 32'(in_ready16), 32'd0);
      step();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd4);
    chk({tag, "_sum"}, 32'(sum16), 32'(es));
    chk({tag, "_cout"}, 32'(cout16), 32'(ec));
    chk({tag, "_carries"}, 32'(carries16), 32'(ecar));
`ifdef RIPPLE_ADDER_OVERFLOW_EN
    chk({tag, "_overflow"}, 32'(ovf16), 32'(eo));
`else
    if (eo === 1'bx) $display("note: unexpected x in overflow expectation");
`endif
  endtask

  task automatic release16(input string tag);
    out_ready16 = 1'b1;
    step();
    out_ready16 = 1'b0;
    chk({tag, "_out_valid_after_hs"}, 32'(out_valid16), 32'd0);
    chk({tag, "_in_ready_after_hs"}, 32'(in_ready16), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int rises;
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] full;
    logic [9:0] e;

    in_valid16 = 0; out_ready16 = 0; a16 = 0; b16 = 0; cin16 = 0;
    in_valid8  = 0; out_ready8  = 0; a8  = 0; b8  = 0; cin8  = 0;

    // Reset state
    rst = 1'b1;
    step(); step();
    chk("rst_in_ready", 32'(in_ready16), 32'd0);
    chk("rst_out_valid", 32'(out_valid16), 32'd0);
    chk("rst_sum", 32'(sum16), 32'd0);
    chk("rst_cout", 32'(cout16), 32'd0);
    chk("rst_carries", 32'(carries16), 32'd0);
    chk("rst_state", 32'(st16), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready16), 32'd1);

    // 1) all-ones plus one
    op16("t1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 4'b1111, 1'b0);
    release16("t1");

    // 2) no carries, cin=1
    op16("t2", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 4'b0000, 1'b0);
    release16("t2");

    // 3) backpressure: hold result for 5 cycles with a new request pending
    op16("t3", 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 4'b0111, 1'b0);
    in_valid16 = 1'b1; a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_out_valid", 32'(out_valid16), 32'd1);
      chk("t3_hold_sum", 32'(sum16), 32'h1000);
      chk("t3_hold_carries", 32'(carries16), 32'b0111);
      chk("t3_hold_in_ready", 32'(in_ready16), 32'd0);
    end
    in_valid16 = 1'b0;
    release16("t3");
    chk("t3_sum_held_idle", 32'(sum16), 32'h1000);

    // 4) reset on the third RUN cycle abandons the operation
    a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0; in_valid16 = 1'b1;
    step();                       // accept edge
    in_valid16 = 1'b0;
    step(); step();               // two RUN edges; now in third RUN cycle
    chk("t4_mid_run_state", 32'(st16), 32'd1);
    rst = 1'b1;
    step();
    chk("t4_rst_out_valid", 32'(out_valid16), 32'd0);
    chk("t4_rst_sum", 32'(sum16), 32'd0);
    chk("t4_rst_cout", 32'(cout16), 32'd0);
    chk("t4_rst_carries", 32'(carries16), 32'd0);
    chk("t4_rst_in_ready", 32'(in_ready16), 32'd0);
    rst = 1'b0;
    #1;
    chk("t4_in_ready_after_rst", 32'(in_ready16), 32'd1);
    rises = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid16) rises++;
    end
    chk("t4_no_out_valid", 32'(rises), 32'd0);

    // 5) signed overflow cases (sum/cout/carries checked in every build)
    op16("t5a", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 4'b0111, 1'b1);
    release16("t5a");
    op16("t5b", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 4'b1000, 1'b1);
    release16("t5b");
    op16("t5c", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 4'b1111, 1'b0);
    release16("t5c");

    // 6) single-chunk instance: 8'hF0 + 8'h0F + 1
    a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1; in_valid8 = 1'b1;
    chk("t6_in_ready", 32'(in_ready8), 32'd1);
    step();
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 20) begin step(); n++; end
    chk("t6_latency", 32'(n), 32'd1);
    chk("t6_sum", 32'(sum8), 32'h00);
    chk("t6_cout", 32'(cout8), 32'd1);
    chk("t6_carries", 32'(carries8), 32'd1);
    out_ready8 = 1'b1;
    step();
    chk("t6_out_valid_after_hs", 32'(out_valid8), 32'd0);

    // 6b) randomized back-to-back operations against a+b+cin
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      exp_q.push_back({(ra[7] == rb[7]) && (full[7] != ra[7]), full});
      a8 = ra; b8 = rb; cin8 = rc; in_valid8 = 1'b1;
      n = 0;
      while (!in_ready8 && n < 10) begin step(); n++; end
      chk("t6r_in_ready", 32'(in_ready8), 32'd1);
      step();
      in_valid8 = 1'b0;
      n = 0;
      while (!out_valid8 && n < 10) begin step(); n++; end
      chk("t6r_latency", 32'(n), 32'd1);
      e = exp_q.pop_front();
      chk("t6r_sum", 32'(sum8), 32'(e[7:0]));
      chk("t6r_cout", 32'(cout8), 32'(e[8]));
      chk("t6r_carries", 32'(carries8), 32'(e[8]));
`ifdef RIPPLE_ADDER_OVERFLOW_EN
      chk("t6r_overflow", 32'(ovf8), 32'(e[9]));
`endif
      step();   // out_ready8 held high: handshake edge
    end
    chk("t6r_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
